// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - default geometry and legality check for pipelined_adder
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 4;

    function automatic bit params_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple-carry adder built from full-adder cells
module adder_slice #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out
);

    logic [CHUNK:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[CHUNK];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep ripple-carry adder, one chunk per stage, valid/ready handshake
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CHUNK = WIDTH / STAGES;

    if (!params_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [STAGES-1:0]            carry_q, carry_d, valid_q, valid_d;

    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in;
    logic [STAGES-1:0]            carry_in, valid_in;
    logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
    logic [STAGES-1:0]            chunk_cout;

    logic stall;

    assign stall     = valid_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = carry_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]     = a;
            assign b_in[k]     = b;
            assign sum_in[k]   = '0;
            assign carry_in[k] = c_in;
            assign valid_in[k] = in_valid;
        end else begin : g_body
            assign a_in[k]     = a_q[k-1];
            assign b_in[k]     = b_q[k-1];
            assign sum_in[k]   = sum_q[k-1];
            assign carry_in[k] = carry_q[k-1];
            assign valid_in[k] = valid_q[k-1];
        end

        adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a     (a_in[k][k*CHUNK +: CHUNK]),
            .b     (b_in[k][k*CHUNK +: CHUNK]),
            .c_in  (carry_in[k]),
            .sum   (chunk_sum[k]),
            .c_out (chunk_cout[k])
        );
    end

    // Data registers load on every non-stall cycle; only the valid chain decides what is observable.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = valid_q;
        if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_d[k]                    = a_in[k];
                b_d[k]                    = b_in[k];
                sum_d[k]                  = sum_in[k];
                sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
                carry_d[k]                = chunk_cout[k];
                valid_d[k]                = valid_in[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    // Already-consumed operand chunks ride along in the skew registers but are never read.
    logic unused_skew;
    assign unused_skew = ^{a_q, b_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder across several geometries
module tb_pipelined_adder;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 9'(c);
    endfunction

    // Main instance: WIDTH=8, STAGES=4
    logic       rst, iv, irdy, cin, ov, ordy, cout;
    logic [7:0] a, b, sum;

    pipelined_adder #(.WIDTH(8), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv),
        .in_ready  (irdy),
        .a         (a),
        .b         (b),
        .c_in      (cin),
        .out_valid (ov),
        .out_ready (ordy),
        .sum       (sum),
        .c_out     (cout)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic [8:0] mq[$];
    int         delivered;

    // Called at the negedge: records the transfers that the coming rising edge performs.
    task automatic observe_main();
        if (ov && ordy) begin
            chk("bp_out_expected", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) begin
                chk("bp_order", {cout, sum}, mq[0]);
                void'(mq.pop_front());
                delivered++;
            end
        end
        if (iv && irdy) mq.push_back(ref_add8(a, b, cin));
    endtask

    // Extra geometries: {4,2} exhaustive, {8,1} and {8,8} random
    function automatic int cfg_w(input int i);
        return (i == 0) ? 4 : 8;
    endfunction
    function automatic int cfg_s(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 1 : 8);
    endfunction
    function automatic int cfg_n(input int i);
        return (i == 0) ? 512 : 1000;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W  = cfg_w(gi);
        localparam int S  = cfg_s(gi);
        localparam int NV = cfg_n(gi);

        logic         rst_g, iv_g, irdy_g, cin_g, ov_g, ordy_g, cout_g;
        logic [W-1:0] a_g, b_g, sum_g;
        logic         done = 1'b0;

        pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst       (rst_g),
            .in_valid  (iv_g),
            .in_ready  (irdy_g),
            .a         (a_g),
            .b         (b_g),
            .c_in      (cin_g),
            .out_valid (ov_g),
            .out_ready (ordy_g),
            .sum       (sum_g),
            .c_out     (cout_g)
        );

        initial begin
            logic [W:0] q[$];
            int idx, recv, cyc, lat;
            rst_g = 1'b1; iv_g = 1'b0; ordy_g = 1'b1;
            a_g = '0; b_g = '0; cin_g = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("cfg%0d_reset_out_valid", gi), 32'(ov_g), 32'd0);
            chk($sformatf("cfg%0d_reset_sum", gi), 32'({cout_g, sum_g}), 32'd0);
            @(negedge clk) rst_g = 1'b0;

            @(posedge clk); #1;
            a_g = '1; b_g = W'(1); cin_g = 1'b1; iv_g = 1'b1;
            @(posedge clk); #1;
            iv_g = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!ov_g && lat < 40) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            chk($sformatf("cfg%0d_latency", gi), 32'(lat), 32'(S));
            chk($sformatf("cfg%0d_latency_value", gi), 32'({cout_g, sum_g}), 32'((1 << W) + 1));
            repeat (S + 2) @(posedge clk);

            idx = 0; recv = 0; cyc = 0;
            while (recv < NV && cyc < 20000) begin
                @(posedge clk); #1;
                if (idx < NV) begin
                    iv_g = ($urandom_range(0, 3) != 0);
                    if (gi == 0) begin
                        a_g   = W'(idx);
                        b_g   = W'(idx >> W);
                        cin_g = idx[2*W];
                    end else begin
                        a_g   = W'($urandom);
                        b_g   = W'($urandom);
                        cin_g = 1'($urandom);
                    end
                end else begin
                    iv_g = 1'b0;
                end
                ordy_g = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                if (ov_g && ordy_g) begin
                    chk($sformatf("cfg%0d_out_expected", gi), 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        chk($sformatf("cfg%0d_result", gi), 32'({cout_g, sum_g}), 32'(q[0]));
                        void'(q.pop_front());
                    end
                    recv++;
                end
                if (iv_g && irdy_g) begin
                    q.push_back({1'b0, a_g} + {1'b0, b_g} + (W + 1)'(cin_g));
                    idx++;
                end
                cyc++;
            end
            iv_g = 1'b0;
            chk($sformatf("cfg%0d_received", gi), 32'(recv), 32'(NV));
            chk($sformatf("cfg%0d_leftover", gi), 32'(q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        vec_t tbl[8];
        int   lat, n, w;
        logic [8:0] held;

        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        tbl[1] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        tbl[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; cin = 1'b0;
        delivered = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(ov), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_c_out", 32'(cout), 32'd0);
        chk("reset_in_ready", 32'(irdy), 32'd1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", 32'(irdy), 32'd1);
        chk("post_reset_out_valid", 32'(ov), 32'd0);

        // 0xFF + 0x01: latency counted with the accept edge as edge 1
        @(posedge clk); #1;
        a = 8'hFF; b = 8'h01; cin = 1'b0; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!ov && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("ff01_latency", 32'(lat), 32'd4);
        chk("ff01_sum", 32'(sum), 32'h00);
        chk("ff01_c_out", 32'(cout), 32'd1);
        repeat (4) @(posedge clk);

        // Back-to-back table stream, results on consecutive cycles
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (t < 8) begin
                iv = 1'b1; a = tbl[t].a; b = tbl[t].b; cin = tbl[t].cin;
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            if (t >= 4) begin
                chk($sformatf("stream_valid_%0d", t - 4), 32'(ov), 32'd1);
                chk($sformatf("stream_sum_%0d", t - 4), 32'(sum), 32'(tbl[t-4].exp_sum));
                chk($sformatf("stream_c_out_%0d", t - 4), 32'(cout), 32'(tbl[t-4].exp_cout));
            end else begin
                chk($sformatf("stream_idle_%0d", t), 32'(ov), 32'd0);
            end
        end
        repeat (4) @(posedge clk);

        // Backpressure: fill with out_ready low, hold 10 cycles, release while still feeding
        ordy = 1'b0;
        mq.delete();
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            iv = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            if (!irdy) break;
            mq.push_back(ref_add8(a, b, cin));
            n++;
        end
        chk("bp_fill_count", 32'(mq.size()), 32'd4);
        held = {cout, sum};
        chk("bp_head", 32'(held), 32'(mq[0]));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            a = 8'($urandom); b = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready_low", 32'(irdy), 32'd0);
            chk("bp_out_valid_held", 32'(ov), 32'd1);
            chk("bp_result_stable", 32'({cout, sum}), 32'(held));
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        #1;
        chk("bp_release_in_ready", 32'(irdy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            observe_main();
            @(posedge clk); #1;
            if (i < 2) begin
                iv = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end else begin
                iv = 1'b0;
            end
        end
        chk("bp_delivered", 32'(delivered), 32'd7);
        chk("bp_queue_empty", 32'(mq.size()), 32'd0);
        @(negedge clk);
        chk("bp_no_duplicate", 32'(ov), 32'd0);

        // Reset with three results in flight and the head result on the output
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                iv = 1'b1; a = 8'($urandom); b = 8'($urandom); cin = 1'b1;
            end else begin
                iv = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("rst_pre_out_valid", 32'(ov), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(ov), 32'd0);
        chk("rst_async_sum", 32'(sum), 32'd0);
        chk("rst_async_c_out", 32'(cout), 32'd0);
        chk("rst_async_in_ready", 32'(irdy), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 32'(ov), 32'd0);
        end

        w = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        chk("configs_done", 32'(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
